// File: rtl/gbe_status_pkg.sv
// Shared types and CTRL word layout for the gbe RX status snapshot controller.
// CTRL bit positions use OPB big-endian numbering (bit 0 = MSB).
package gbe_status_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned CTRL_IDX       = 0;
    localparam int unsigned CTRL_COUNT_POS = 0;
    localparam int unsigned CTRL_COUNT_W   = 16;
    localparam int unsigned CTRL_MASK_POS  = 16;
    localparam int unsigned CTRL_TOUT_BIT  = 29;
    localparam int unsigned CTRL_DONE_BIT  = 30;
    localparam int unsigned CTRL_BUSY_BIT  = 31;
    localparam int unsigned CTRL_ARM_BIT   = 31;
    localparam int unsigned CTRL_ARM_BE    = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT
    } bus_state_t;

    typedef enum logic {
        CAP_IDLE,
        CAPTURE
    } cap_state_t;

endpackage

// File: rtl/gbe_rx_status_snapshot_ctrl_opb_slave_if.sv
// OPB slave front end: window decode, one-cycle registered ack and read data,
// and a write strobe with the latched word index, data and byte enables.
module opb_slave_if
    import gbe_status_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h010C0100,
    parameter logic [31:0] C_HIGHADDR = 32'h010C01FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:31] abus,
    input  logic [0:3]  be,
    input  logic [0:31] dbus,
    input  logic        rnw,
    input  logic        select,
    input  word_t       rd_data,
    output word_t       rd_idx,
    output logic        wr_stb,
    output word_t       wr_idx,
    output logic [0:31] wr_data,
    output logic [0:3]  wr_be,
    output logic [0:31] sl_dbus,
    output logic        xfer_ack
);

    bus_state_t state, state_next;
    logic       hit;
    logic       wr_pend;
    word_t      offset;
    logic [1:0] unused_offset;

    assign hit    = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign offset = abus - C_BASEADDR;
    assign rd_idx = {2'b00, offset[31:2]};
    assign unused_offset = offset[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (select && hit) state_next = ACK;
            ACK:     state_next = WAIT;
            WAIT:    if (!select) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ack and read data are registered together so both are high for the ACK cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_ack <= 1'b0;
            sl_dbus  <= '0;
            wr_pend  <= 1'b0;
            wr_idx   <= '0;
            wr_data  <= '0;
            wr_be    <= '0;
        end else begin
            xfer_ack <= (state_next == ACK);
            sl_dbus  <= '0;
            if (state == IDLE && state_next == ACK) begin
                sl_dbus <= rnw ? rd_data : '0;
                wr_pend <= !rnw;
                wr_idx  <= rd_idx;
                wr_data <= dbus;
                wr_be   <= be;
            end
        end
    end

    assign wr_stb = (state == ACK) && wr_pend;

endmodule

// File: rtl/gbe_rx_status_snapshot_ctrl.sv
// Snapshot controller: software arms a capture, each status word is latched on its
// valid strobe, and the sequence ends on a complete mask or a timeout.
module gbe_rx_status_snapshot_ctrl
    import gbe_status_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR  = 32'h010C0100,
    parameter logic [31:0] C_HIGHADDR  = 32'h010C01FF,
    parameter int unsigned C_NUM_WORDS = 4,
    parameter int unsigned C_TIMEOUT   = 1024
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:31]               OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:31]               OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:31]               Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [C_NUM_WORDS*32-1:0] status_in,
    input  logic [C_NUM_WORDS-1:0]    status_valid,
    output logic                      snap_busy
);

    localparam logic [15:0] TIMER_LOAD = 16'(C_TIMEOUT - 1);

    word_t       rd_idx, rd_data, wr_idx;
    logic        wr_stb;
    logic [0:31] wr_data;
    logic [0:3]  wr_be;
    logic [0:31] ctrl_word;
    logic        arm;

    cap_state_t             cap_state, cap_next;
    logic [C_NUM_WORDS-1:0] mask, latch_en;
    logic                   complete, expire;
    logic                   done, timeout, busy;
    logic [15:0]            count, timer;
    word_t                  snap [C_NUM_WORDS];

    logic unused_bits;
    assign unused_bits = ^{OPB_seqAddr, wr_data[0:30], wr_be[0:2]};

    opb_slave_if #(
        .C_BASEADDR(C_BASEADDR),
        .C_HIGHADDR(C_HIGHADDR)
    ) u_opb (
        .clk      (OPB_Clk),
        .rst_n    (OPB_Rst_n),
        .abus     (OPB_ABus),
        .be       (OPB_BE),
        .dbus     (OPB_DBus),
        .rnw      (OPB_RNW),
        .select   (OPB_select),
        .rd_data  (rd_data),
        .rd_idx   (rd_idx),
        .wr_stb   (wr_stb),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .sl_dbus  (Sl_DBus),
        .xfer_ack (Sl_xferAck)
    );

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign snap_busy  = busy;

    assign arm = wr_stb && (wr_idx == CTRL_IDX) && wr_be[CTRL_ARM_BE] && wr_data[CTRL_ARM_BIT];

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_COUNT_POS +: CTRL_COUNT_W] = count;
        for (int unsigned i = 0; i < C_NUM_WORDS; i++) ctrl_word[CTRL_MASK_POS + i] = mask[i];
        ctrl_word[CTRL_TOUT_BIT] = timeout;
        ctrl_word[CTRL_DONE_BIT] = done;
        ctrl_word[CTRL_BUSY_BIT] = busy;
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx == CTRL_IDX) rd_data = ctrl_word;
        for (int unsigned i = 0; i < C_NUM_WORDS; i++)
            if (rd_idx == i + 1) rd_data = snap[i];
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) cap_state <= CAP_IDLE;
        else            cap_state <= cap_next;
    end

    // An arm in CAPTURE restarts the sequence; that cycle's strobes are dropped.
    always_comb begin
        cap_next = cap_state;
        latch_en = '0;
        complete = 1'b0;
        expire   = 1'b0;
        case (cap_state)
            CAP_IDLE: if (arm) cap_next = CAPTURE;
            CAPTURE: begin
                if (!arm) begin
                    latch_en = status_valid & ~mask;
                    if ((mask | latch_en) == '1) begin
                        complete = 1'b1;
                        cap_next = CAP_IDLE;
                    end else if (timer == '0) begin
                        expire   = 1'b1;
                        cap_next = CAP_IDLE;
                    end
                end
            end
            default: cap_next = CAP_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            mask    <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
            count   <= '0;
            timer   <= '0;
            for (int unsigned i = 0; i < C_NUM_WORDS; i++) snap[i] <= '0;
        end else if (arm) begin
            mask    <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b1;
            timer   <= TIMER_LOAD;
        end else if (cap_state == CAPTURE) begin
            for (int unsigned i = 0; i < C_NUM_WORDS; i++)
                if (latch_en[i]) snap[i] <= status_in[32*i +: 32];
            mask <= mask | latch_en;
            if (complete) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                count <= count + 16'd1;
            end else if (expire) begin
                timeout <= 1'b1;
                busy    <= 1'b0;
            end else begin
                timer <= timer - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gbe_rx_status_snapshot_ctrl.sv
// Directed bench: OPB reads push expected words to a scoreboard queue, popped at ack.
module tb_gbe_rx_status_snapshot_ctrl;

    localparam logic [31:0] BASE = 32'h010C0100;
    localparam logic [31:0] HIGH = 32'h010C01FF;
    localparam int unsigned NW   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [0:31]       abus = '0;
    logic [0:3]        be = '0;
    logic [0:31]       dbus = '0;
    logic              rnw = 1'b0;
    logic              select = 1'b0;
    logic              seq_addr = 1'b0;
    logic [0:31]       sl_dbus;
    logic              xfer_ack, err_ack, retry, tout_sup, busy;
    logic [NW*32-1:0]  status_in = '0;
    logic [NW-1:0]     status_valid = '0;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    gbe_rx_status_snapshot_ctrl #(
        .C_BASEADDR (BASE),
        .C_HIGHADDR (HIGH),
        .C_NUM_WORDS(NW),
        .C_TIMEOUT  (16)
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst_n   (rst_n),
        .OPB_ABus    (abus),
        .OPB_BE      (be),
        .OPB_DBus    (dbus),
        .OPB_RNW     (rnw),
        .OPB_select  (select),
        .OPB_seqAddr (seq_addr),
        .Sl_DBus     (sl_dbus),
        .Sl_xferAck  (xfer_ack),
        .Sl_errAck   (err_ack),
        .Sl_retry    (retry),
        .Sl_toutSup  (tout_sup),
        .status_in   (status_in),
        .status_valid(status_valid),
        .snap_busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl(input logic [15:0] cnt, input logic [7:0] m,
                                         input logic t, input logic d, input logic b);
        logic [0:31] w;
        w = '0;
        w[0:15] = cnt;
        for (int i = 0; i < 8; i++) w[16 + i] = m[i];
        w[29] = t;
        w[30] = d;
        w[31] = b;
        return w;
    endfunction

    task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        status_in = {w3, w2, w1, w0};
    endtask

    // One OPB transfer; ack must appear exactly one cycle after select is seen.
    task automatic bus(input string tag, input logic [31:0] addr, input logic r,
                       input logic [0:3] b, input logic [31:0] d,
                       input logic hit, input logic [31:0] exp);
        logic [31:0] e;
        if (r && hit) exp_q.push_back(exp);
        @(posedge clk); #1;
        abus = addr; rnw = r; be = b; dbus = d; select = 1'b1;
        @(negedge clk);
        check({tag, "_ack_early"}, {31'd0, xfer_ack}, 32'd0);
        @(negedge clk);
        check({tag, "_ack"}, {31'd0, xfer_ack}, {31'd0, hit});
        if (r && hit) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            check({tag, "_rdata"}, sl_dbus, e);
        end else begin
            check({tag, "_dbus_zero"}, sl_dbus, 32'd0);
        end
        @(posedge clk); #1;
        select = 1'b0; abus = '0; dbus = '0; be = '0; rnw = 1'b0;
        @(negedge clk);
        check({tag, "_ack_single"}, {31'd0, xfer_ack}, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus(tag, addr, 1'b1, 4'b1111, 32'd0, 1'b1, exp);
    endtask

    task automatic arm_cap(input string tag);
        bus(tag, BASE, 1'b0, 4'b1111, 32'h0000_0001, 1'b1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned pulses;
        logic [31:0] e;

        // 1: reset state
        repeat (3) @(negedge clk);
        check("rst_dbus", sl_dbus, 32'd0);
        check("rst_outs", {27'd0, xfer_ack, err_ack, retry, tout_sup, busy}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        rd("rst_ctrl", BASE, 32'd0);
        rd("rst_snap0", BASE + 32'h4, 32'd0);

        // 2: full capture on the first CAPTURE cycle
        set_words(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        arm_cap("arm1");
        check("busy_cap1", {31'd0, busy}, 32'd1);
        status_valid = 4'b1111;
        @(posedge clk); #1 status_valid = '0;
        for (int i = 0; i < 4; i++)
            rd("snap_full", BASE + 32'(4 * (i + 1)), 32'hA0 + 32'(i));
        rd("ctrl_done1", BASE, ctrl(16'd1, 8'h0F, 1'b0, 1'b1, 1'b0));

        // 3: timeout with only word 0 captured
        set_words(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        arm_cap("arm2");
        status_valid = 4'b0001;
        @(posedge clk); #1 status_valid = '0;
        repeat (14) @(posedge clk);
        #1 check("busy_before_tout", {31'd0, busy}, 32'd1);
        @(posedge clk); #1 check("busy_after_tout", {31'd0, busy}, 32'd0);
        rd("ctrl_tout", BASE, ctrl(16'd1, 8'h01, 1'b1, 1'b0, 1'b0));
        rd("tout_snap0", BASE + 32'h4, 32'hB0);
        for (int i = 1; i < 4; i++)
            rd("tout_snap_kept", BASE + 32'(4 * (i + 1)), 32'hA0 + 32'(i));

        // 4: re-arm mid capture clears the mask, then a full recapture
        set_words(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        arm_cap("arm3");
        status_valid = 4'b0001;
        @(posedge clk); #1 status_valid = '0;
        arm_cap("rearm");
        rd("ctrl_rearm", BASE, ctrl(16'd1, 8'h00, 1'b0, 1'b0, 1'b1));
        rd("rearm_snap0_kept", BASE + 32'h4, 32'hC0);
        set_words(32'hD0, 32'hD1, 32'hD2, 32'hD3);
        status_valid = 4'b1111;
        @(posedge clk); #1 status_valid = '0;
        rd("ctrl_done2", BASE, ctrl(16'd2, 8'h0F, 1'b0, 1'b1, 1'b0));
        rd("recap_snap0", BASE + 32'h4, 32'hD0);
        rd("recap_snap3", BASE + 32'h10, 32'hD3);

        // 5: ignored writes, unused index, out-of-window accesses
        bus("wr_be_low", BASE, 1'b0, 4'b1110, 32'h0000_0001, 1'b1, 32'd0);
        check("busy_no_arm", {31'd0, busy}, 32'd0);
        rd("ctrl_no_arm", BASE, ctrl(16'd2, 8'h0F, 1'b0, 1'b1, 1'b0));
        bus("wr_snap0", BASE + 32'h4, 1'b0, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'd0);
        rd("snap0_unchanged", BASE + 32'h4, 32'hD0);
        rd("unused_idx", BASE + 32'h14, 32'd0);
        rd("last_word", HIGH - 32'h3, 32'd0);
        bus("miss_high", HIGH + 32'h4, 1'b1, 4'b1111, 32'd0, 1'b0, 32'd0);
        bus("miss_low", BASE - 32'h4, 1'b0, 4'b1111, 32'h1, 1'b0, 32'd0);
        check("busy_no_arm2", {31'd0, busy}, 32'd0);

        // 6: select held for several cycles yields one ack pulse
        exp_q.push_back(32'hD1);
        @(posedge clk); #1;
        abus = BASE + 32'h8; rnw = 1'b1; be = 4'b1111; select = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (xfer_ack) begin
                pulses++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                check("hold_rdata", sl_dbus, e);
            end
        end
        check("hold_pulses", pulses, 32'd1);
        @(posedge clk); #1 select = 1'b0; abus = '0; rnw = 1'b0; be = '0;
        rd("after_hold", BASE + 32'hC, 32'hD2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
